// File: rtl/key_entry_pkg.sv
// Shared types and key/operator encodings for the keypad entry buffer.
// Used by key_debounce and key_entry_buffer.
package key_entry_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_ADD       = 4'd10;
  localparam logic [3:0] KEY_SUB       = 4'd11;
  localparam logic [3:0] KEY_MUL       = 4'd12;
  localparam logic [3:0] KEY_DIV       = 4'd13;
  localparam logic [3:0] KEY_EQ        = 4'd14;
  localparam logic [3:0] KEY_CLR       = 4'd15;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= KEY_DIGIT_MAX;
  endfunction

  function automatic logic is_operator(input logic [3:0] key);
    return (key >= KEY_ADD) && (key <= KEY_EQ);
  endfunction

  // Operator keys are contiguous, so the opcode is just the offset from ADD.
  function automatic logic [2:0] to_opcode(input logic [3:0] key);
    logic [3:0] offset;
    offset = key - KEY_ADD;
    return offset[2:0];
  endfunction

endpackage

// File: rtl/key_entry_buffer_if.sv
// Scanner-side inputs and ALU-side event handshake of the key entry buffer.
// master = the entry buffer, slave = scanner/ALU environment.
interface key_entry_buffer_if #(
  parameter int NDIGITS = 8
) ();
  localparam int OPW = 4 * NDIGITS;
  localparam int CW  = $clog2(NDIGITS + 1);

  logic           KeyRead;
  logic [3:0]     BCDKey;
  logic [OPW-1:0] operand;
  logic [CW-1:0]  digitCount;
  logic           opValid;
  logic [2:0]     opCode;
  logic [OPW-1:0] opOperand;
  logic           opReady;
  logic           entryOverflow;

  modport master (
    input  KeyRead, BCDKey, opReady,
    output operand, digitCount, opValid, opCode, opOperand, entryOverflow
  );

  modport slave (
    output KeyRead, BCDKey, opReady,
    input  operand, digitCount, opValid, opCode, opOperand, entryOverflow
  );
endinterface

// File: rtl/key_entry_buffer_debounce.sv
// Debounce FSM: turns the scanner KeyRead/BCDKey level pair into a single
// one-cycle accept per press; accepts are stalled while hold_i is high.
module key_debounce
  import key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       key_read_i,
  input  logic [3:0] bcd_key_i,
  input  logic       hold_i,
  output logic       key_accept_o,
  output logic [3:0] key_code_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  // The cycle that moved the FSM out of IDLE/HELD already counts as sample one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]     key_lat_q, key_lat_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_lat_q <= key_lat_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_lat_d    = key_lat_q;
    key_accept_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_read_i) begin
          state_d   = PRESS_WAIT;
          key_lat_d = bcd_key_i;
          cnt_d     = CNT_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!key_read_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bcd_key_i != key_lat_q) begin
          key_lat_d = bcd_key_i;
          cnt_d     = CNT_ONE;
        end else if (cnt_q >= CNT_LAST && !hold_i) begin
          key_accept_o = 1'b1;
          state_d      = HELD;
          cnt_d        = '0;
        end else begin
          // While stalled the count saturates so the press fires as soon as hold drops.
          cnt_d = cnt_inc;
        end
      end

      HELD: begin
        if (!key_read_i) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      RELEASE_WAIT: begin
        if (key_read_i) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_code_o = key_lat_q;

endmodule

// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: BCD operand shift register, digit counter and the
// operator event register handed to the ALU. Option: LEADING_ZERO_SUPPRESS_EN.
module key_entry_buffer
  import key_entry_pkg::*;
#(
  parameter int NDIGITS         = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  key_entry_buffer_if.master bus
);

  localparam int OPW = 4 * NDIGITS;
  localparam int CW  = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(NDIGITS);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  logic           key_accept;
  logic [3:0]     key_code;
  logic           lz_drop;

  logic [OPW-1:0] operand_q, operand_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           op_valid_q, op_valid_d;
  logic [2:0]     op_code_q, op_code_d;
  logic [OPW-1:0] op_operand_q, op_operand_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK          (CLK),
    .RESET        (RESET),
    .key_read_i   (bus.KeyRead),
    .bcd_key_i    (bus.BCDKey),
    .hold_i       (op_valid_q),
    .key_accept_o (key_accept),
    .key_code_o   (key_code)
  );

`ifdef LEADING_ZERO_SUPPRESS_EN
  assign lz_drop = (key_code == 4'd0) && (count_q == '0);
`else
  assign lz_drop = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      operand_q    <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      op_valid_q   <= 1'b0;
      op_code_q    <= '0;
      op_operand_q <= '0;
    end else begin
      operand_q    <= operand_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      op_valid_q   <= op_valid_d;
      op_code_q    <= op_code_d;
      op_operand_q <= op_operand_d;
    end
  end

  always_comb begin
    operand_d    = operand_q;
    count_d      = count_q;
    overflow_d   = 1'b0;
    op_valid_d   = op_valid_q;
    op_code_d    = op_code_q;
    op_operand_d = op_operand_q;

    if (op_valid_q && bus.opReady) begin
      op_valid_d = 1'b0;
    end

    // Accepts never coincide with op_valid_q=1: the debouncer is held off then.
    if (key_accept) begin
      if (is_digit(key_code)) begin
        if (lz_drop) begin
          operand_d = operand_q;
        end else if (count_q < COUNT_FULL) begin
          operand_d = OPW'({operand_q, key_code});
          count_d   = count_q + COUNT_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (is_operator(key_code)) begin
        op_valid_d   = 1'b1;
        op_code_d    = to_opcode(key_code);
        op_operand_d = operand_q;
        operand_d    = '0;
        count_d      = '0;
      end else begin
        // Clear wipes the entry only; an outstanding event is left for the ALU.
        operand_d = '0;
        count_d   = '0;
      end
    end
  end

  assign bus.operand       = operand_q;
  assign bus.digitCount    = count_q;
  assign bus.entryOverflow = overflow_q;
  assign bus.opValid       = op_valid_q;
  assign bus.opCode        = op_code_q;
  assign bus.opOperand     = op_operand_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Scoreboard bench for key_entry_buffer (NDIGITS=4, DEBOUNCE_CYCLES=4): stimulus
// queues the expected output snapshot of each change, a monitor pops and compares.
module tb_key_entry_buffer;

  localparam int ND = 4;
  localparam int DB = 4;

  typedef struct packed {
    logic [15:0] operand;
    logic [2:0]  count;
    logic        ovf;
    logic        opv;
    logic [2:0]  opc;
    logic [15:0] opop;
  } snap_t;

  logic CLK;
  logic RESET;
  int   n_total = 0;
  int   n_pass  = 0;
  int   ovf_cycles;
  snap_t exp_q[$];

  key_entry_buffer_if #(.NDIGITS(ND)) bus ();

  key_entry_buffer #(
    .NDIGITS        (ND),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input logic ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic snap_t mk(input logic [15:0] op, input logic [2:0] cnt,
                               input logic ovf, input logic opv,
                               input logic [2:0] opc, input logic [15:0] opop);
    snap_t s;
    s.operand = op;
    s.count   = cnt;
    s.ovf     = ovf;
    s.opv     = opv;
    s.opc     = opc;
    s.opop    = opop;
    return s;
  endfunction

  function automatic snap_t entry(input logic [15:0] op, input logic [2:0] cnt);
    return mk(op, cnt, 1'b0, 1'b0, 3'd0, 16'h0);
  endfunction

  function automatic snap_t sample();
    return mk(bus.operand, bus.digitCount, bus.entryOverflow, bus.opValid,
              bus.opCode, bus.opOperand);
  endfunction

  // Monitor: every change of the output snapshot must match the next queued one.
  initial begin
    snap_t prev, cur, e;
    prev = '0;
    forever begin
      @(posedge CLK);
      #1;
      cur = sample();
      if (cur != prev) begin
        check(exp_q.size() != 0, "unexpected_event", 64'(cur), 64'(0));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          // opCode/opOperand only carry meaning while opValid is high.
          if (!e.opv) begin
            cur.opc  = e.opc;
            cur.opop = e.opop;
          end
          check(cur == e, "event", 64'(cur), 64'(e));
        end
        prev = sample();
      end
    end
  end

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (bus.entryOverflow) ovf_cycles++;
    end
  endtask

  task automatic press(input logic [3:0] key);
    ovf_cycles = 0;
    bus.BCDKey  = key;
    bus.KeyRead = 1'b1;
    hold_cycles(10);
    bus.KeyRead = 1'b0;
    hold_cycles(10);
  endtask

  task automatic press_exp(input logic [3:0] key, input snap_t s);
    exp_q.push_back(s);
    press(key);
  endtask

  initial begin
    RESET       = 1'b0;
    bus.KeyRead = 1'b0;
    bus.BCDKey  = 4'd0;
    bus.opReady = 1'b0;
    repeat (3) @(negedge CLK);
    check(bus.operand == 16'h0, "reset_operand", 64'(bus.operand), 64'h0);
    check(bus.digitCount == 3'd0, "reset_count", 64'(bus.digitCount), 64'h0);
    check(bus.opValid == 1'b0, "reset_opvalid", 64'(bus.opValid), 64'h0);
    check(bus.entryOverflow == 1'b0, "reset_overflow", 64'(bus.entryOverflow), 64'h0);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);

    // Three clean presses.
    press_exp(4'd1, entry(16'h0001, 3'd1));
    press_exp(4'd2, entry(16'h0012, 3'd2));
    press_exp(4'd3, entry(16'h0123, 3'd3));
    check(bus.operand == 16'h0123, "three_digits", 64'(bus.operand), 64'h0123);
    check(bus.digitCount == 3'd3, "three_count", 64'(bus.digitCount), 64'h3);

    // Short glitch: 3 sampled cycles is below the debounce threshold.
    bus.BCDKey  = 4'd7;
    bus.KeyRead = 1'b1;
    repeat (3) @(negedge CLK);
    bus.KeyRead = 1'b0;
    repeat (10) @(negedge CLK);
    check(bus.operand == 16'h0123, "glitch_ignored", 64'(bus.operand), 64'h0123);

    // Bounce, then a stable hold: exactly one digit.
    bus.BCDKey = 4'd4;
    for (int i = 0; i < 2; i++) begin
      bus.KeyRead = 1'b1;
      repeat (2) @(negedge CLK);
      bus.KeyRead = 1'b0;
      repeat (2) @(negedge CLK);
    end
    press_exp(4'd4, entry(16'h1234, 3'd4));
    check(bus.digitCount == 3'd4, "bounce_one_digit", 64'(bus.digitCount), 64'h4);

    // Overflow on the fifth digit.
    press_exp(4'd15, entry(16'h0000, 3'd0));
    press_exp(4'd5, entry(16'h0005, 3'd1));
    press_exp(4'd6, entry(16'h0056, 3'd2));
    press_exp(4'd7, entry(16'h0567, 3'd3));
    press_exp(4'd8, entry(16'h5678, 3'd4));
    check(ovf_cycles == 0, "no_overflow_on_8", 64'(ovf_cycles), 64'h0);
    exp_q.push_back(mk(16'h5678, 3'd4, 1'b1, 1'b0, 3'd0, 16'h0));
    press_exp(4'd9, entry(16'h5678, 3'd4));
    check(ovf_cycles == 1, "overflow_width", 64'(ovf_cycles), 64'h1);
    check(bus.operand == 16'h5678, "overflow_operand", 64'(bus.operand), 64'h5678);

    // Operator event with the ALU not ready.
    press_exp(4'd15, entry(16'h0000, 3'd0));
    press_exp(4'd4, entry(16'h0004, 3'd1));
    press_exp(4'd2, entry(16'h0042, 3'd2));
    press_exp(4'd10, mk(16'h0000, 3'd0, 1'b0, 1'b1, 3'd0, 16'h0042));
    check(bus.opValid == 1'b1, "op_valid", 64'(bus.opValid), 64'h1);
    check(bus.opOperand == 16'h0042, "op_operand", 64'(bus.opOperand), 64'h0042);

    // A digit pressed while the event is pending stalls.
    bus.BCDKey  = 4'd3;
    bus.KeyRead = 1'b1;
    repeat (10) @(negedge CLK);
    check(bus.digitCount == 3'd0, "stalled_press", 64'(bus.digitCount), 64'h0);
    check(bus.opCode == 3'd0 && bus.opOperand == 16'h0042, "op_stable",
          64'({bus.opCode, bus.opOperand}), 64'({3'd0, 16'h0042}));
    exp_q.push_back(entry(16'h0000, 3'd0));
    exp_q.push_back(entry(16'h0003, 3'd1));
    bus.opReady = 1'b1;
    @(negedge CLK);
    bus.opReady = 1'b0;
    repeat (3) @(negedge CLK);
    check(bus.opValid == 1'b0, "op_consumed", 64'(bus.opValid), 64'h0);
    check(bus.operand == 16'h0003, "stalled_accepted", 64'(bus.operand), 64'h3);
    bus.KeyRead = 1'b0;
    repeat (10) @(negedge CLK);

    // Asynchronous reset in the middle of a press.
    exp_q.push_back(entry(16'h0000, 3'd0));
    bus.BCDKey  = 4'd6;
    bus.KeyRead = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check(bus.operand == 16'h0 && bus.digitCount == 3'd0, "async_reset_entry",
          64'({bus.operand, bus.digitCount}), 64'h0);
    check(bus.opOperand == 16'h0 && !bus.opValid && !bus.entryOverflow, "async_reset_op",
          64'({bus.opOperand, bus.opValid, bus.entryOverflow}), 64'h0);
    @(negedge CLK);
    RESET = 1'b1;
    exp_q.push_back(entry(16'h0006, 3'd1));
    repeat (3) @(negedge CLK);
    check(bus.digitCount == 3'd0, "redebounce_wait", 64'(bus.digitCount), 64'h0);
    @(negedge CLK);
    check(bus.digitCount == 3'd1, "redebounce_accept", 64'(bus.digitCount), 64'h1);
    bus.KeyRead = 1'b0;
    repeat (10) @(negedge CLK);

    // Leading zeros.
    press_exp(4'd15, entry(16'h0000, 3'd0));
`ifdef LEADING_ZERO_SUPPRESS_EN
    press(4'd0);
    press(4'd0);
    press_exp(4'd5, entry(16'h0005, 3'd1));
    check(bus.digitCount == 3'd1, "lz_count", 64'(bus.digitCount), 64'h1);
`else
    press_exp(4'd0, entry(16'h0000, 3'd1));
    press_exp(4'd0, entry(16'h0000, 3'd2));
    press_exp(4'd5, entry(16'h0005, 3'd3));
    check(bus.digitCount == 3'd3, "lz_count", 64'(bus.digitCount), 64'h3);
`endif
    check(bus.operand == 16'h0005, "lz_operand", 64'(bus.operand), 64'h0005);

    repeat (5) @(negedge CLK);
    check(exp_q.size() == 0, "events_outstanding", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
